// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: angle format, arctangent table and FSM states.
package cordic_pkg;

    // Angle format: 2^ANG_FRAC LSB per radian
    localparam int ANG_FRAC   = 14;
    localparam int PI_2       = 25736;
    localparam int PI         = 2 * PI_2;

    // atan(2^-i) in angle LSBs, i = 0..13
    localparam int ATAN_DEPTH = 14;
    localparam int ATAN_TAB [ATAN_DEPTH] = '{
        12868, 7596, 4014, 2037, 1023, 512, 256,
        128,   64,   32,   16,   8,    4,   2
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROTATE,
        S_DONE
    } state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup indexed by iteration number.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int BITS = 16,
    parameter int SW   = 4
) (
    input  logic [SW-1:0]   step,
    output logic [BITS-1:0] atan
);

    // Table lookup; steps beyond the table contribute no rotation
    always_comb begin
        atan = '0;
        if (int'(step) < ATAN_DEPTH) begin
            atan = BITS'(ATAN_TAB[step]);
        end
    end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: (x,y) -> (K*|v|, atan2(y,x)), one step per clock.
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int BITS  = 16,
    parameter int STEPS = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [BITS:0] x_in,
    input  logic signed [BITS:0] y_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [BITS+2:0]     mag,
    output logic signed [BITS:0] angle,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int W  = BITS + 3;   // headroom for gain K and negating the minimum input
    localparam int ZW = BITS + 2;   // angle accumulator, wide enough for PI + atan[0]
    localparam int SW = 4;

    state_t                 state_q, state_d;
    logic [SW-1:0]          step_q, step_d;
    logic signed [W-1:0]    x_q, x_d, y_q, y_d;
    logic signed [ZW-1:0]   z_q, z_d;
    logic                   zero_q, zero_d;
    logic [W-1:0]           mag_q, mag_d;
    logic signed [BITS:0]   angle_q, angle_d;
    logic                   out_valid_q, out_valid_d;

    logic [BITS-1:0]        atan;
    logic signed [ZW-1:0]   atan_ext;
    logic signed [W-1:0]    x_ext, y_ext, x_sh, y_sh;
    logic                   accept;

    cordic_atan_rom #(.BITS(BITS), .SW(SW)) u_rom (
        .step (step_q),
        .atan (atan)
    );

    assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign accept   = in_valid & in_ready;

    assign x_ext    = W'(x_in);
    assign y_ext    = W'(y_in);
    assign x_sh     = x_q >>> step_q;
    assign y_sh     = y_q >>> step_q;
    assign atan_ext = $signed({{(ZW-BITS){1'b0}}, atan});

    assign mag       = mag_q;
    assign angle     = angle_q;
    assign out_valid = out_valid_q;

    // Next-state: operand load (with left-half-plane fold), micro-rotation, result capture
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        zero_d      = zero_q;
        mag_d       = mag_q;
        angle_d     = angle_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    // Fold x<0 into the right half-plane by a PI rotation so CORDIC converges
                    if (x_in[BITS]) begin
                        x_d = -x_ext;
                        y_d = -y_ext;
                        z_d = y_in[BITS] ? -ZW'(PI) : ZW'(PI);
                    end else begin
                        x_d = x_ext;
                        y_d = y_ext;
                        z_d = '0;
                    end
                    zero_d      = (x_in == '0) && (y_in == '0);
                    step_d      = '0;
                    out_valid_d = 1'b0;
                    state_d     = S_ROTATE;
                end else if (state_q == S_DONE && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_ROTATE: begin
                // Drive y toward zero; z accumulates the rotation applied
                if (!y_q[W-1]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_ext;
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_ext;
                end
                step_d = step_q + 1'b1;
                if (step_q == SW'(STEPS - 1)) begin
                    mag_d       = x_d;
                    angle_d     = zero_q ? '0 : z_d[BITS:0];
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            zero_q      <= 1'b0;
            mag_q       <= '0;
            angle_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            zero_q      <= zero_d;
            mag_q       <= mag_d;
            angle_q     <= angle_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Scoreboard bench for cordic_vectoring: directed vectors, decoupled monitor.
module tb_cordic_vectoring;

    localparam int BITS  = 16;
    localparam int STEPS = 14;
    localparam int W     = BITS + 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [BITS:0] x_in, y_in;
    logic                 in_valid, in_ready;
    logic [W-1:0]         mag;
    logic signed [BITS:0] angle;
    logic                 out_valid, out_ready;

    cordic_vectoring #(.BITS(BITS), .STEPS(STEPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .x_in      (x_in),
        .y_in      (y_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mag       (mag),
        .angle     (angle),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    mag;
        int    ang;
        int    acc;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int exp, int tol);
        n_total++;
        if (act >= exp - tol && act <= exp + tol) n_pass++;
        else $display("FAIL %s: got %0d want %0d (tol %0d)", name, act, exp, tol);
    endtask

    // Monitor: checks each result as it appears, hold stability while stalled
    initial begin
        bit   prev_ov = 1'b0;
        int   held_mag = 0, held_ang = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_ov = 1'b0;
            end else begin
                if (out_valid) begin
                    if (!prev_ov) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_out_valid", 1, 0, 0);
                        end else begin
                            e = exp_q[0];
                            chk({e.name, "_latency"}, cyc - e.acc, STEPS, 0);
                            chk({e.name, "_mag"}, int'(mag), e.mag, 6);
                            chk({e.name, "_angle"}, int'(angle), e.ang, 3);
                        end
                        held_mag = int'(mag);
                        held_ang = int'(angle);
                    end else begin
                        chk("hold_mag", int'(mag), held_mag, 0);
                        chk("hold_angle", int'(angle), held_ang, 0);
                    end
                    if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
                end
                prev_ov = out_valid;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send(string name, int x, int y, int emag, int eang);
        exp_t e;
        bit   done = 1'b0;
        x_in     = (BITS+1)'(x);
        y_in     = (BITS+1)'(y);
        in_valid = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            #1;
            if (in_ready) begin
                e.mag  = emag;
                e.ang  = eang;
                e.acc  = cyc + 1;
                e.name = name;
                exp_q.push_back(e);
                done = 1'b1;
                @(posedge clk);
                @(negedge clk);
            end else begin
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        if (!done) chk({name, "_accept_timeout"}, 0, 1, 0);
    endtask

    task automatic drain(string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (exp_q.size() != 0) begin
            chk({name, "_result_timeout"}, exp_q.size(), 0, 0);
            exp_q.delete();
        end
    endtask

    task automatic run(string name, int x, int y, int emag, int eang);
        @(negedge clk);
        send(name, x, y, emag, eang);
        drain(name);
    endtask

    initial begin
        int n;
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        x_in      = '0;
        y_in      = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_out_valid", int'(out_valid), 0, 0);
        chk("reset_mag", int'(mag), 0, 0);
        chk("reset_angle", int'(angle), 0, 0);
        chk("reset_in_ready", int'(in_ready), 1, 0);
        @(negedge clk);
        rst = 1'b0;

        run("x_axis",        16384,      0,  26981,      0);
        run("diag_q1",       16384,  16384,  38156,  12868);
        run("pos_y_axis",        0,  16384,  26981,  25736);
        run("neg_y_axis",        0, -16384,  26981, -25736);
        run("neg_x_axis",   -16384,      0,  26981,  51472);
        run("diag_q3",      -16384, -16384,  38156, -38604);
        run("origin",            0,      0,      0,      0);
        run("neg_x_min",    -65536,      0, 107921,  51472);

        // Stall in DONE, then same-cycle release and accept
        @(negedge clk);
        out_ready = 1'b0;
        send("stall_a", 16384, 16384, 38156, 12868);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("stall_a_seen", int'(out_valid), 1, 0);
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("stall_in_ready", int'(in_ready), 0, 0);
            chk("stall_out_valid", int'(out_valid), 1, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        send("stall_b", -16384, 16384, 38156, 38604);
        #1;
        chk("b2b_out_valid_drop", int'(out_valid), 0, 0);
        drain("stall_b");

        // Abort a job with reset at iteration 5
        @(negedge clk);
        send("aborted", 16384, 0, 26981, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", int'(in_ready), 1, 0);
        chk("abort_out_valid", int'(out_valid), 0, 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("abort_no_result", seen, 0, 0);
        run("after_abort", 16384, 16384, 38156, 12868);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
